// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver with a first-word fall-through receive FIFO.
//   The serial line is double-flopped.
//   The receive FSM (IDLE, START, DATA, STOP, WAIT_IDLE) samples each bit at
//   its centre using a down-counter.
//   Good frames are pushed into the FIFO.
//   Bad stop bits and FIFO overflows are reported as one-cycle pulses.
//
// Parameters
//   clk_per_bit : clock cycles per UART bit (4..65535)
//   fifo_depth  : receive FIFO entries (power of 2, 2..16)
//
// Ports
//   clock       : single rising-edge clock
//   reset       : asynchronous active-low reset
//   uart_rx     : asynchronous serial input, idles high
//   data        : byte at the FIFO head
//   valid       : FIFO non-empty
//   ready       : consumer pop request (pop when valid && ready)
//   frame_error : one-cycle pulse on a bad stop bit
//   overrun     : one-cycle pulse when a good byte is dropped (FIFO full)
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int clk_per_bit = 217,
    parameter int fifo_depth  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CW   = $clog2(clk_per_bit + 1);
    localparam int AW   = $clog2(fifo_depth);
    localparam int OCCW = AW + 1;

    localparam logic [CW-1:0]   HALF_BIT = CW'(clk_per_bit / 2);
    localparam logic [CW-1:0]   FULL_BIT = CW'(clk_per_bit);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [OCCW-1:0] OCC_FULL = OCCW'(fifo_depth);
    localparam logic [OCCW-1:0] OCC_ONE  = OCCW'(1);
    localparam logic [OCCW-1:0] OCC_ZERO = OCCW'(0);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_s_q;
    logic            cnt_expire_s;
    logic            push_s;
    logic            ferr_s;

    logic [7:0]      mem_q [fifo_depth];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCCW-1:0] occ_q, occ_d;
    logic            full_s, pop_s, wr_en_s, ovr_s;
    logic            frame_error_q, overrun_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // The counter is reloaded with a non-zero value, so "expired" means the
    // final cycle of the interval; <= also guards against an underflow.
    assign cnt_expire_s = (cnt_q <= CNT_ONE);

    // Receive FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receive FSM next-state logic and push / framing-error decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_expire_s) begin
                    if (rx_s_q) begin
                        // Line back high at the start-bit centre: glitch.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = FULL_BIT;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_expire_s) begin
                    // LSB first: shift in at the top, the first bit lands in bit 0.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_expire_s) begin
                    if (rx_s_q) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_IDLE: begin
                // A line still low after a framing error is not a start bit.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The FIFO can accept a push when full only if a pop frees a slot
    // in the same cycle. Pops need valid, so an empty FIFO never bypasses.
    assign full_s  = (occ_q == OCC_FULL);
    assign valid   = (occ_q != OCC_ZERO);
    assign pop_s   = valid && ready;
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign ovr_s   = push_s && full_s && !pop_s;
    assign data    = mem_q[rd_ptr_q];

    // FIFO occupancy update.
    always_comb begin
        occ_d = occ_q;
        case ({wr_en_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // FIFO storage, pointers (wrap modulo depth) and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= OCC_ZERO;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            occ_q <= occ_d;
        end
    end

    // Registered error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_error_q <= ferr_s;
            overrun_q     <= ovr_s;
        end
    end

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Self-checking bench for uart_receiver.
//   The main DUT runs at 4 clocks per bit with a 4-deep FIFO.
//   A second DUT runs at 8 clocks per bit for the glitch scenario.
//   Frames are generated serially.
//   A monitor records popped bytes and error pulses.
//   Expected results come from a byte-level model (queue of good bytes,
//   count of bad stops).
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB   = 4;
    localparam int CPB8  = 8;
    localparam int DEPTH = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_rx8 = 1'b1;
    logic       ready   = 1'b0;
    logic       ready8  = 1'b1;
    logic [7:0] data, data8;
    logic       valid, valid8;
    logic       frame_error, frame_error8;
    logic       overrun, overrun8;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc = 0;
    int stop_t = -1;
    int rise_cyc = -1;
    int vcyc_cnt, fe_cnt, ov_cnt, v8_cnt, fe8_cnt, ov8_cnt;
    logic valid_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] got8_q[$];

    uart_receiver #(.clk_per_bit(CPB), .fifo_depth(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx), .data(data),
        .valid(valid), .ready(ready), .frame_error(frame_error), .overrun(overrun)
    );

    uart_receiver #(.clk_per_bit(CPB8), .fifo_depth(DEPTH)) u_dut8 (
        .clock(clock), .reset(reset), .uart_rx(uart_rx8), .data(data8),
        .valid(valid8), .ready(ready8), .frame_error(frame_error8), .overrun(overrun8)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (valid && ready) got_q.push_back(data);
                if (valid) vcyc_cnt++;
                if (valid && !valid_prev) rise_cyc = cyc;
                if (frame_error) fe_cnt++;
                if (overrun) ov_cnt++;
                if (valid8 && ready8) got8_q.push_back(data8);
                if (valid8) v8_cnt++;
                if (frame_error8) fe8_cnt++;
                if (overrun8) ov8_cnt++;
            end
            valid_prev = valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        got_q.delete();
        got8_q.delete();
        vcyc_cnt = 0; fe_cnt = 0; ov_cnt = 0;
        v8_cnt = 0; fe8_cnt = 0; ov8_cnt = 0;
        rise_cyc = -1;
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) uart_rx8 = v;
        else uart_rx = v;
    endtask

    task automatic drive_bit(input bit which, input logic v, input int cpb);
        @(posedge clock); #1;
        set_line(which, v);
        repeat (cpb - 1) @(posedge clock);
    endtask

    // One 8N1 frame; a bad stop keeps the line low for extra_low more bit
    // times and then returns it high for one bit time.
    task automatic send_frame(input bit which, input logic [7:0] b, input logic stop, input int extra_low);
        int cpb;
        cpb = which ? CPB8 : CPB;
        drive_bit(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(which, b[i], cpb);
        @(posedge clock); #1;
        set_line(which, stop);
        stop_t = cyc;
        repeat (cpb - 1) @(posedge clock);
        if (!stop) begin
            repeat (extra_low * cpb) @(posedge clock);
            drive_bit(which, 1'b1, cpb);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({valid, data, frame_error, overrun} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b data=%h fe=%b ov=%b, want all 0", valid, data, frame_error, overrun);
        end
        tests_run++;
        if ({valid8, data8, frame_error8, overrun8} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs8: got valid=%b data=%h fe=%b ov=%b, want all 0", valid8, data8, frame_error8, overrun8);
        end
        @(posedge clock); #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: valid=%b want 0", valid);
        end
    endtask

    task automatic test_single();
        ready = 1'b1;
        clear_mon();
        send_frame(1'b0, 8'hA5, 1'b1, 0);
        repeat (3 * CPB) @(posedge clock);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_a5: got %0d bytes first=%h, want 1 byte a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        tests_run++;
        if (vcyc_cnt != 1 || fe_cnt != 0 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL single_pulses: valid_cycles=%0d fe=%0d ov=%0d, want 1/0/0", vcyc_cnt, fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int fe_exp;
        logic [7:0] b;
        logic stop;
        fe_exp = 0;
        ready = 1'b1;
        clear_mon();
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom());
            stop = ($urandom_range(0, 3) != 0);
            if (stop) exp_q.push_back(b);
            else fe_exp++;
            send_frame(1'b0, b, stop, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2 * CPB)) @(posedge clock);
        end
        repeat (3 * CPB) @(posedge clock);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_byte[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (fe_cnt != fe_exp || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL random_pulses: fe=%0d ov=%0d, want fe=%0d ov=0", fe_cnt, ov_cnt, fe_exp);
        end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        clear_mon();
        for (int v = 1; v <= 4; v++) send_frame(1'b0, 8'(v), 1'b1, 0);
        repeat (2 * CPB) @(posedge clock);
        tests_run++;
        if (ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL overrun_early: ov=%0d after 4 bytes, want 0", ov_cnt);
        end
        send_frame(1'b0, 8'h05, 1'b1, 0);
        repeat (3 * CPB) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (ov_cnt != 1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: ov=%0d, want 1", ov_cnt);
        end
        tests_run++;
        if (valid !== 1'b1 || data !== 8'h01 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL overrun_hold: valid=%b data=%h pops=%0d, want 1/01/0", valid, data, got_q.size());
        end
        @(posedge clock); #1 ready = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (got_q.size() != 4) begin
            tests_failed++;
            $display("FAIL overrun_drain_count: got %0d pops, want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL overrun_drain[%0d]: got %h, want %h", i, got_q[i], 8'(i + 1));
            end
        end
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_empty: valid=%b, want 0", valid);
        end
    endtask

    task automatic test_frame_error();
        ready = 1'b1;
        clear_mon();
        send_frame(1'b0, 8'h3C, 1'b0, 2);
        repeat (3 * CPB) @(posedge clock);
        tests_run++;
        if (fe_cnt != 1 || got_q.size() != 0 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL frame_error: fe=%0d pops=%0d ov=%0d, want 1/0/0", fe_cnt, got_q.size(), ov_cnt);
        end
        send_frame(1'b0, 8'h77, 1'b1, 0);
        repeat (3 * CPB) @(posedge clock);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'h77 || fe_cnt != 1) begin
            tests_failed++;
            $display("FAIL after_frame_error: pops=%0d first=%h fe=%0d, want 1/77/1", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, fe_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(posedge clock); #1 uart_rx8 = 1'b0;
        @(posedge clock); #1 uart_rx8 = 1'b1;
        repeat (4 * CPB8) @(posedge clock);
        tests_run++;
        if (v8_cnt != 0 || fe8_cnt != 0 || ov8_cnt != 0) begin
            tests_failed++;
            $display("FAIL glitch: valid_cycles=%0d fe=%0d ov=%0d, want 0/0/0", v8_cnt, fe8_cnt, ov8_cnt);
        end
        send_frame(1'b1, 8'h96, 1'b1, 0);
        repeat (3 * CPB8) @(posedge clock);
        tests_run++;
        if (got8_q.size() != 1 || got8_q[0] !== 8'h96) begin
            tests_failed++;
            $display("FAIL glitch_then_frame: pops=%0d first=%h, want 1/96", got8_q.size(), (got8_q.size() > 0) ? got8_q[0] : 8'hxx);
        end
    endtask

    // The push cycle is the one before valid rises on an empty FIFO; the
    // offset from the stop-bit start is measured once and then used to
    // line up a single pop with the push into a full FIFO.
    task automatic test_full_pop();
        logic [7:0] b[5];
        int d;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom());
        ready = 1'b0;
        clear_mon();
        send_frame(1'b0, b[0], 1'b1, 0);
        repeat (2 * CPB) @(posedge clock);
        tests_run++;
        if (rise_cyc < 0) begin
            tests_failed++;
            $display("FAIL full_pop_calibrate: valid never rose, want a rise");
        end
        d = rise_cyc - stop_t;
        for (int i = 1; i < 4; i++) send_frame(1'b0, b[i], 1'b1, 0);
        repeat (2 * CPB) @(posedge clock);
        stop_t = -1;
        fork
            send_frame(1'b0, b[4], 1'b1, 0);
            begin
                wait (stop_t >= 0);
                if (d >= 2) begin
                    repeat (d - 1) @(posedge clock);
                    #1 ready = 1'b1;
                    @(posedge clock); #1 ready = 1'b0;
                end
            end
        join
        repeat (2 * CPB) @(posedge clock);
        tests_run++;
        if (ov_cnt != 0 || got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL full_pop_same_cycle: ov=%0d pops=%0d (offset %0d), want 0/1", ov_cnt, got_q.size(), d);
        end
        @(posedge clock); #1 ready = 1'b1;
        repeat (12) @(posedge clock);
        tests_run++;
        if (got_q.size() != 5) begin
            tests_failed++;
            $display("FAIL full_pop_count: got %0d bytes, want 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== b[i]) begin
                tests_failed++;
                $display("FAIL full_pop_order[%0d]: got %h, want %h", i, got_q[i], b[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] ab;
        ab = 8'hC3;
        ready = 1'b1;
        clear_mon();
        drive_bit(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, ab[i], CPB);
        @(posedge clock); #1 uart_rx = 1'b1;
        repeat (CPB / 2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (valid !== 1'b0 || frame_error !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset_outputs: valid=%b fe=%b ov=%b, want 0/0/0", valid, frame_error, overrun);
        end
        @(posedge clock); #1 reset = 1'b1;
        repeat (3 * CPB) @(posedge clock);
        send_frame(1'b0, 8'h5A, 1'b1, 0);
        repeat (3 * CPB) @(posedge clock);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A || fe_cnt != 0 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL midframe_reset_recover: pops=%0d first=%h fe=%0d ov=%0d, want 1/5a/0/0", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, fe_cnt, ov_cnt);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_random();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_full_pop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter clk_per_bit, default 217, SHALL set the clock cycles per UART bit (115200 baud at 25 MHz); legal range 4..65535.
REQ-002 Parameter fifo_depth, default 4, SHALL set the receive FIFO entries; legal values are powers of 2, from 2 to 16.
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port uart_rx, input, 1 bit, SHALL be the asynchronous serial line; it idles high.
REQ-006 Port data, output, 8 bits, SHALL carry the byte at the FIFO head.
REQ-007 Port valid, output, 1 bit, SHALL be high while the FIFO is non-empty.
REQ-008 Port ready, input, 1 bit, SHALL be the consumer pop request; a pop occurs when valid and ready are both high.
REQ-009 Port frame_error, output, 1 bit, SHALL be a one-cycle pulse on a bad stop bit.
REQ-010 Port overrun, output, 1 bit, SHALL be a one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: when rx_s is 0, go to START and load the bit counter with clk_per_bit/2 (integer division).
REQ-014 START: when the counter expires, sample rx_s. If it is 1, the start was a glitch: return to IDLE and push nothing. If it is 0, go to DATA and reload the counter with clk_per_bit.
REQ-015 DATA: sample 8 bits, LSB first, one sample every clk_per_bit cycles at bit centre; after the 8th sample, go to STOP.
REQ-016 STOP: sample rx_s after clk_per_bit cycles. If it is 1, push the byte and go to IDLE. If it is 0, pulse frame_error, discard the byte and go to WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rx_s is 1, then go to IDLE; a low line after a framing error SHALL NOT start a new frame.
REQ-018 A pushed byte SHALL appear on data, with valid high, in the cycle after the stop sample.
REQ-019 The FIFO SHALL be first-word fall-through; data SHALL be stable while valid is high and ready is low.
REQ-020 A push while the FIFO is full and no pop occurs SHALL drop the new byte and pulse overrun; FIFO contents are unchanged.
REQ-021 A push and a pop in the same cycle while the FIFO is full SHALL both succeed without overrun; occupancy is unchanged.
REQ-022 A push and a pop in the same cycle while the FIFO is empty SHALL NOT bypass; valid rises in the next cycle.
REQ-023 Read and write pointers SHALL wrap modulo fifo_depth; the full/empty decision SHALL use an extra pointer MSB or an occupancy counter of log2(fifo_depth)+1 bits.
REQ-024 A pop while the FIFO is empty SHALL be ignored.
REQ-025 The counter SHALL be wide enough for clk_per_bit; no other arithmetic overflow is permitted.

Reset
REQ-026 While reset is low: FSM = IDLE, FIFO empty, valid = 0, data = 0, frame_error = 0, overrun = 0, both synchronizer flops = 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a push or error pulse; after release, reception restarts at the next falling edge.
REQ-028 Reset deassertion is synchronized externally; the block SHALL tolerate a low uart_rx at release by treating it as a start edge.

Verification
REQ-029 clk_per_bit=4, ready=1, send frame 0xA5 with a good stop -> exactly one valid cycle with data=0xA5, no error pulses.
REQ-030 ready=0, send 0x01, 0x02, 0x03, 0x04, 0x05 with fifo_depth=4 -> one overrun pulse on the 5th byte; then raising ready pops 0x01..0x04 in order, and valid falls after the 4th pop.
REQ-031 Send 0x3C with stop bit = 0 and the line held low for 3 bit times -> one frame_error pulse, no push, no new frame until the line returns high.
REQ-032 Low glitch on uart_rx of 1 cycle (clk_per_bit=8) -> FSM returns to IDLE, no push, no pulses.
REQ-033 FIFO full, with a pop and the stop-bit push in the same cycle -> no overrun; the new byte ends up last in the FIFO.
REQ-034 Assert reset during DATA bit 4 of a frame, then send 0x5A -> only 0x5A is received.
